// File: rtl/flag_branch_resolve_unit_if.sv
// Branch-resolve bus: ID-stage decode inputs, EX-stage flag inputs, and the
// take/link/stall/flush controls returned to the fetch and PC logic.
interface flag_branch_resolve_unit_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [10:0]      id_opcode;
  logic [3:0]       id_cond;
  logic             id_rt_zero;
  logic             ex_set_flags;
  logic [3:0]       ex_flags;
  logic [3:0]       flags;
  logic             take_branch;
  logic             br_reg;
  logic             link;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output id_valid, id_opcode, id_cond, id_rt_zero, ex_set_flags, ex_flags,
    input  flags, take_branch, br_reg, link, stall, flush, taken_count
  );

  modport slave (
    input  id_valid, id_opcode, id_cond, id_rt_zero, ex_set_flags, ex_flags,
    output flags, take_branch, br_reg, link, stall, flush, taken_count
  );
endinterface

// File: rtl/flag_branch_resolve_unit.sv
// Resolves B/BL/BR/CBZ/B.cond in ID against the architectural NZCV register,
// forwarding flags from an EX-stage setter or stalling one cycle for them.
// Flag bit order everywhere: [3]=C, [2]=Z, [1]=V, [0]=N.
module flag_branch_resolve_unit #(
  parameter bit FWD_EX = 1'b1,
  parameter int CNT_W  = 16
) (
  input logic                       clk,
  input logic                       reset,
  flag_branch_resolve_unit_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_flags;
  logic             r_flush;
  logic [CNT_W-1:0] r_count;

  logic       w_is_b, w_is_bl, w_is_cbz, w_is_bcond, w_is_br;
  logic [3:0] w_flag_src;
  logic       w_stall;
  logic       w_take_raw;
  logic       w_take;

  // Evaluates an A64 condition code against a flag nibble.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic c, z, v, n;
    c = f[3];
    z = f[2];
    v = f[1];
    n = f[0];
    case (cond)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = !z;
      4'h2:    cond_eval = c;
      4'h3:    cond_eval = !c;
      4'h4:    cond_eval = n;
      4'h5:    cond_eval = !n;
      4'h6:    cond_eval = v;
      4'h7:    cond_eval = !v;
      4'h8:    cond_eval = c && !z;
      4'h9:    cond_eval = !(c && !z);
      4'hA:    cond_eval = (n == v);
      4'hB:    cond_eval = (n != v);
      4'hC:    cond_eval = !z && (n == v);
      4'hD:    cond_eval = !(!z && (n == v));
      default: cond_eval = 1'b1;
    endcase
  endfunction

  // Branch-class decode; a bubble in ID decodes as nothing.
  always_comb begin
    w_is_b     = bus.id_valid && (bus.id_opcode[10:5] == 6'b000101);
    w_is_bl    = bus.id_valid && (bus.id_opcode[10:5] == 6'b100101);
    w_is_cbz   = bus.id_valid && (bus.id_opcode[10:3] == 8'b10110100);
    w_is_bcond = bus.id_valid && (bus.id_opcode[10:3] == 8'b01010100);
    w_is_br    = bus.id_valid && (bus.id_opcode == 11'b11010110000);
  end

  // Next state, stall and flag source; HOLD always reads the register,
  // which the departing setter has just written.
  always_comb begin
    w_state_nxt = IDLE;
    w_stall     = 1'b0;
    w_flag_src  = r_flags;
    case (r_state)
      IDLE: begin
        if (FWD_EX && bus.ex_set_flags) begin
          w_flag_src = bus.ex_flags;
        end
        if (!FWD_EX && w_is_bcond && bus.ex_set_flags) begin
          w_stall     = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Taken decision, suppressed while stalling or held in reset.
  always_comb begin
    w_take_raw = 1'b0;
    if (w_is_b || w_is_bl || w_is_br) begin
      w_take_raw = 1'b1;
    end else if (w_is_cbz) begin
      w_take_raw = bus.id_rt_zero;
    end else if (w_is_bcond) begin
      w_take_raw = cond_eval(bus.id_cond, w_flag_src);
    end
    w_take = w_take_raw && !w_stall && !reset;
  end

  assign bus.take_branch = w_take;
  assign bus.br_reg      = w_take && w_is_br;
  assign bus.link        = w_take && w_is_bl;
  assign bus.stall       = w_stall && !reset;
  assign bus.flush       = r_flush;
  assign bus.flags       = r_flags;
  assign bus.taken_count = r_count;

  // Architectural flags: written by any EX setter, regardless of stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (bus.ex_set_flags) begin
      r_flags <= bus.ex_flags;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush pulse follows a taken branch by one cycle; taken counter wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush <= 1'b0;
      r_count <= '0;
    end else begin
      r_flush <= w_take;
      if (w_take) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_flag_branch_resolve_unit.sv
// Bench for flag_branch_resolve_unit: forwarding, stalling and 4-bit-counter
// instances driven in lockstep and compared against a behavioural model.
module tb_flag_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid = 1'b0;
  logic [10:0] id_opcode = '0;
  logic [3:0]  id_cond = '0;
  logic        id_rt_zero = 1'b0;
  logic        ex_set_flags = 1'b0;
  logic [3:0]  ex_flags = '0;

  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_BL   = 11'b10010100011;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_BC   = 11'b01010100000;
  localparam logic [10:0] OP_BR   = 11'b11010110000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;

  flag_branch_resolve_unit_if #(.CNT_W(16)) if_f ();
  flag_branch_resolve_unit_if #(.CNT_W(16)) if_s ();
  flag_branch_resolve_unit_if #(.CNT_W(4))  if_w ();

  assign if_f.id_valid = id_valid;   assign if_s.id_valid = id_valid;   assign if_w.id_valid = id_valid;
  assign if_f.id_opcode = id_opcode; assign if_s.id_opcode = id_opcode; assign if_w.id_opcode = id_opcode;
  assign if_f.id_cond = id_cond;     assign if_s.id_cond = id_cond;     assign if_w.id_cond = id_cond;
  assign if_f.id_rt_zero = id_rt_zero; assign if_s.id_rt_zero = id_rt_zero; assign if_w.id_rt_zero = id_rt_zero;
  assign if_f.ex_set_flags = ex_set_flags; assign if_s.ex_set_flags = ex_set_flags; assign if_w.ex_set_flags = ex_set_flags;
  assign if_f.ex_flags = ex_flags;   assign if_s.ex_flags = ex_flags;   assign if_w.ex_flags = ex_flags;

  flag_branch_resolve_unit #(.FWD_EX(1'b1), .CNT_W(16)) u_fwd (.clk(clk), .reset(reset), .bus(if_f));
  flag_branch_resolve_unit #(.FWD_EX(1'b0), .CNT_W(16)) u_stl (.clk(clk), .reset(reset), .bus(if_s));
  flag_branch_resolve_unit #(.FWD_EX(1'b1), .CNT_W(4))  u_w4  (.clk(clk), .reset(reset), .bus(if_w));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model state
  logic [3:0] m_flags;
  bit         m_hold;
  bit         m_flush_f, m_flush_s;
  int         m_cnt_f, m_cnt_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 none, 1 B, 2 BL, 3 CBZ, 4 B.cond, 5 BR
  function automatic int kind_of(input logic [10:0] op);
    if (op ==? 11'b000101?????) return 1;
    if (op ==? 11'b100101?????) return 2;
    if (op ==? 11'b10110100???) return 3;
    if (op ==? 11'b01010100???) return 4;
    if (op == 11'b11010110000) return 5;
    return 0;
  endfunction

  // Conditions come in complementary pairs; bit 0 inverts, 1110/1111 always.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit cf = f[3];
    bit zf = f[2];
    bit vf = f[1];
    bit nf = f[0];
    bit base;
    case (c[3:1])
      3'd0: base = zf;
      3'd1: base = cf;
      3'd2: base = nf;
      3'd3: base = vf;
      3'd4: base = cf && !zf;
      3'd5: base = (nf == vf);
      3'd6: base = !zf && (nf == vf);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic bit would_take(input int k, input bit rz, input logic [3:0] c, input logic [3:0] f);
    case (k)
      1, 2, 5: return 1'b1;
      3:       return rz;
      4:       return cond_ok(c, f);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000;
    m_hold = 1'b0;
    m_flush_f = 1'b0;
    m_flush_s = 1'b0;
    m_cnt_f = 0;
    m_cnt_s = 0;
  endtask

  task automatic drive(input bit v, input logic [10:0] op, input logic [3:0] c,
                       input bit rz, input bit es, input logic [3:0] ef);
    id_valid = v; id_opcode = op; id_cond = c;
    id_rt_zero = rz; ex_set_flags = es; ex_flags = ef;
  endtask

  // One cycle: drive at posedge+1, check combinational outputs, then
  // check registered outputs just after the next posedge.
  task automatic step(input string tag, input bit v, input logic [10:0] op, input logic [3:0] c,
                      input bit rz, input bit es, input logic [3:0] ef);
    int k;
    bit tf, ts, ss;
    drive(v, op, c, rz, es, ef);
    k = v ? kind_of(op) : 0;
    tf = would_take(k, rz, c, es ? ef : m_flags);
    ss = 1'b0;
    if (m_hold) begin
      ts = would_take(k, rz, c, m_flags);
    end else if (k == 4 && es) begin
      ss = 1'b1;
      ts = 1'b0;
    end else begin
      ts = would_take(k, rz, c, m_flags);
    end
    #1;
    chk({tag, ".f.take"}, 32'(if_f.take_branch), 32'(tf));
    chk({tag, ".f.breg"}, 32'(if_f.br_reg), 32'(tf && k == 5));
    chk({tag, ".f.link"}, 32'(if_f.link), 32'(tf && k == 2));
    chk({tag, ".f.stall"}, 32'(if_f.stall), 32'd0);
    chk({tag, ".s.take"}, 32'(if_s.take_branch), 32'(ts));
    chk({tag, ".s.stall"}, 32'(if_s.stall), 32'(ss));
    chk({tag, ".s.link"}, 32'(if_s.link), 32'(ts && k == 2));
    chk({tag, ".w.take"}, 32'(if_w.take_branch), 32'(tf));
    @(posedge clk);
    if (es) m_flags = ef;
    m_hold = ss;
    m_flush_f = tf;
    m_flush_s = ts;
    if (tf) m_cnt_f++;
    if (ts) m_cnt_s++;
    #1;
    chk({tag, ".f.flags"}, 32'(if_f.flags), 32'(m_flags));
    chk({tag, ".s.flags"}, 32'(if_s.flags), 32'(m_flags));
    chk({tag, ".f.flush"}, 32'(if_f.flush), 32'(m_flush_f));
    chk({tag, ".s.flush"}, 32'(if_s.flush), 32'(m_flush_s));
    chk({tag, ".f.cnt"}, 32'(if_f.taken_count), 32'(m_cnt_f % 65536));
    chk({tag, ".s.cnt"}, 32'(if_s.taken_count), 32'(m_cnt_s % 65536));
    chk({tag, ".w.cnt"}, 32'(if_w.taken_count), 32'(m_cnt_f % 16));
  endtask

  // Reset with a B presented in ID: every output must read zero while held.
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, OP_B, 4'h0, 1'b1, 1'b1, 4'hF);
    #1;
    chk("rst.f.take", 32'(if_f.take_branch), 32'd0);
    chk("rst.s.stall", 32'(if_s.stall), 32'd0);
    chk("rst.f.flags", 32'(if_f.flags), 32'd0);
    chk("rst.f.flush", 32'(if_f.flush), 32'd0);
    chk("rst.f.cnt", 32'(if_f.taken_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 11'd0, 4'h0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    logic [10:0] op;
    model_reset();
    do_reset();

    // B.LT with clear flags is not taken; then SUBS N=1,V=0 with B.LT together.
    step("lt0", 1'b1, OP_BC, 4'hB, 1'b0, 1'b0, 4'b0000);
    step("lt_fwd", 1'b1, OP_BC, 4'hB, 1'b0, 1'b1, 4'b0001);
    chk("lt_fwd.cnt1", 32'(if_f.taken_count), 32'd1);
    chk("lt_fwd.flags", 32'(if_f.flags), 32'b0001);
    step("lt_hold", 1'b1, OP_BC, 4'hB, 1'b0, 1'b0, 4'b0000);
    step("lt_after", 1'b0, OP_BC, 4'hB, 1'b0, 1'b0, 4'b0000);
    chk("lt_after.s.cnt1", 32'(if_s.taken_count), 32'd1);

    // A new setter during HOLD must not affect the HOLD evaluation.
    step("hw0", 1'b1, OP_BC, 4'h0, 1'b0, 1'b1, 4'b0100);
    step("hw1", 1'b1, OP_BC, 4'h0, 1'b0, 1'b1, 4'b0000);

    // CBZ, BL, BR, ADDI.
    step("cbz0", 1'b1, OP_CBZ, 4'h0, 1'b0, 1'b0, 4'h0);
    step("cbz1", 1'b1, OP_CBZ, 4'h0, 1'b1, 1'b0, 4'h0);
    step("bl", 1'b1, OP_BL, 4'h0, 1'b0, 1'b0, 4'h0);
    step("br", 1'b1, OP_BR, 4'h0, 1'b0, 1'b0, 4'h0);
    step("addi", 1'b1, OP_ADDI, 4'hE, 1'b1, 1'b0, 4'h0);
    step("bubble", 1'b0, OP_B, 4'h0, 1'b0, 1'b1, 4'b1010);

    // Full condition sweep from the register.
    for (int f = 0; f < 16; f++) begin
      step("ld", 1'b0, OP_ADDI, 4'h0, 1'b0, 1'b1, 4'(f));
      for (int c = 0; c < 16; c++) begin
        step($sformatf("sw%0h_%0h", f, c), 1'b1, OP_BC, 4'(c), 1'b0, 1'b0, 4'h0);
      end
    end

    // Reset asserted mid-HOLD clears everything immediately.
    step("pre_rst", 1'b1, OP_BC, 4'hB, 1'b0, 1'b1, 4'b0001);
    drive(1'b1, OP_BC, 4'hB, 1'b0, 1'b0, 4'h0);
    #1;
    reset = 1'b1;
    #1;
    chk("mid.s.flags", 32'(if_s.flags), 32'd0);
    chk("mid.s.stall", 32'(if_s.stall), 32'd0);
    chk("mid.s.take", 32'(if_s.take_branch), 32'd0);
    chk("mid.s.flush", 32'(if_s.flush), 32'd0);
    chk("mid.f.flush", 32'(if_f.flush), 32'd0);
    chk("mid.s.cnt", 32'(if_s.taken_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_rst", 1'b1, OP_BC, 4'hB, 1'b0, 1'b0, 4'h0);

    // 16 taken B instructions wrap the 4-bit counter.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step("wrap", 1'b1, OP_B, 4'h0, 1'b0, 1'b0, 4'h0);
    end
    chk("w4_wrap", 32'(if_w.taken_count), 32'd0);
    chk("f_cnt16", 32'(if_f.taken_count), 32'd16);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0: op = {6'b000101, 5'($urandom)};
        1: op = {6'b100101, 5'($urandom)};
        2: op = {8'b10110100, 3'($urandom)};
        3: op = {8'b01010100, 3'($urandom)};
        4: op = OP_BR;
        5: op = OP_ADDI;
        default: op = 11'($urandom);
      endcase
      step("rnd", 1'($urandom_range(0, 3) != 0), op, 4'($urandom), 1'($urandom),
           1'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
